// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multi-channel PWM generator.
package pwm_pkg;

   typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

   localparam int PWM_CH_DEF    = 4;
   localparam int PWM_CNT_W_DEF = 8;

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: double-buffered duty (shadow/active), compare, registered output.
// Output is 1 cycle behind cnt; no backpressure, duty writes are always accepted.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W = PWM_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             boundary,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_data,
   input  logic [CNT_W-1:0] cnt,
   output logic             pwm
);

   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] active;
   logic [CNT_W-1:0] duty_eff;

   // On the boundary the period being started already uses the pending shadow value.
   assign duty_eff = boundary ? shadow : active;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         active <= '0;
         pwm    <= 1'b0;
      end else begin
         if (wr) begin
            shadow <= wr_data;
         end
         if (boundary) begin
            active <= shadow;
         end
         pwm <= en && (cnt < duty_eff);
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter feeding CH compare channels.
// Outputs registered, 1 cycle behind the counter; no backpressure, duty writes always accepted.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter  int CH         = PWM_CH_DEF,
   parameter  int CNT_W      = PWM_CNT_W_DEF,
   parameter  int PERIOD_RST = 2**CNT_W - 1,
   localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [CNT_W-1:0] period,
   input  logic             duty_wr,
   input  logic [CH_W-1:0]  duty_ch,
   input  logic [CNT_W-1:0] duty_data,
   output logic [CH-1:0]    pwm_out,
   output logic             period_start,
   output logic [CNT_W-1:0] cnt_out
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] period_act;
   logic [CNT_W-1:0] p_eff;
   pwm_dir_e         dir;
   pwm_dir_e         dir_nxt;
   pwm_mode_e        mode_act;
   pwm_mode_e        m_eff;
   logic             boundary;

   assign boundary = en && (cnt == '0) && (dir == DIR_UP);

   // The period starting on the boundary runs with the freshly sampled settings.
   assign p_eff = boundary ? period : period_act;
   assign m_eff = boundary ? pwm_mode_e'(mode) : mode_act;

   always_comb begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
      if (en) begin
         if (m_eff == PWM_EDGE) begin
            if (cnt < p_eff) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end else if (dir == DIR_UP) begin
            if (cnt < p_eff) begin
               cnt_nxt = cnt + CNT_W'(1);
            end else if (cnt > CNT_W'(1)) begin
               cnt_nxt = cnt - CNT_W'(1);
               dir_nxt = DIR_DOWN;
            end
         end else if (cnt > CNT_W'(1)) begin
            // Reaching 1 on the way down falls back to 0 with dir up: the next boundary.
            cnt_nxt = cnt - CNT_W'(1);
            dir_nxt = DIR_DOWN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         dir          <= DIR_UP;
         period_act   <= CNT_W'(PERIOD_RST);
         mode_act     <= PWM_EDGE;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         dir          <= dir_nxt;
         period_start <= boundary;
         if (boundary) begin
            period_act <= period;
            mode_act   <= pwm_mode_e'(mode);
         end
      end
   end

   assign cnt_out = cnt;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic wr_sel;
      // Indices at or above CH match no channel, so such writes are dropped.
      assign wr_sel = duty_wr && (duty_ch == CH_W'(i));

      pwm_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .boundary (boundary),
         .wr       (wr_sel),
         .wr_data  (duty_data),
         .cnt      (cnt),
         .pwm      (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed period/duty table, hand sequences, random run vs a period-list model.
module tb_pwm_multi;

   localparam int CH    = 5;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             mode = 1'b0;
   logic [CNT_W-1:0] period = 8'd255;
   logic             duty_wr = 1'b0;
   logic [2:0]       duty_ch = 3'd0;
   logic [CNT_W-1:0] duty_data = 8'd0;
   logic [CH-1:0]    pwm_out;
   logic             period_start;
   logic [CNT_W-1:0] cnt_out;

   always #5 clk = ~clk;

   pwm_multi #(
      .CH    (CH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .period       (period),
      .duty_wr      (duty_wr),
      .duty_ch      (duty_ch),
      .duty_data    (duty_data),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .cnt_out      (cnt_out)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: each period is the explicit list of counter values it visits.
   int            m_sh  [CH];
   int            m_act [CH];
   int            seq [$];
   int            pos = 0;
   int            cur = 0;
   logic [CH-1:0] e_pwm = '0;
   logic          e_ps = 1'b0;
   int            e_cnt = 0;

   int meas_hi [CH];
   int meas_len;
   int acc0;

   typedef struct {
      bit mode;
      int per;
      int duty;
      int exp_hi;
      int exp_len;
   } vec_t;
   vec_t tbl [11];

   function void build_seq(input int p, input bit m);
      seq.delete();
      for (int k = 0; k <= p; k++) seq.push_back(k);
      if (m && p > 0)
         for (int k = p - 1; k >= 1; k--) seq.push_back(k);
   endfunction

   task automatic model_step();
      bit bnd;
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
         end
         seq.delete();
         pos = 0; cur = 0; e_pwm = '0; e_ps = 1'b0; e_cnt = 0;
         return;
      end
      if (!en) begin
         seq.delete();
         pos = 0; cur = 0; e_pwm = '0; e_ps = 1'b0; e_cnt = 0;
      end else begin
         bnd = (pos == 0);
         if (bnd) begin
            for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
            build_seq(int'(period), mode);
         end
         for (int i = 0; i < CH; i++) e_pwm[i] = (cur < m_act[i]);
         e_ps = bnd;
         pos++;
         if (pos >= seq.size()) pos = 0;
         cur = seq[pos];
         e_cnt = cur;
      end
      if (duty_wr && int'(duty_ch) < CH) m_sh[duty_ch] = int'(duty_data);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
      chk("period_start", 32'(period_start), 32'(e_ps));
      chk("cnt_out", 32'(cnt_out), 32'(e_cnt));
   endtask

   // Measures one whole period starting at a period_start cycle; leaves the bench on the next one.
   task automatic measure();
      int w = 0;
      while (!period_start && w < 1100) begin
         tick();
         w++;
      end
      chk("measure_start_seen", 32'(period_start), 1);
      for (int i = 0; i < CH; i++) meas_hi[i] = int'(pwm_out[i]);
      meas_len = 1;
      tick();
      while (!period_start && meas_len < 1100) begin
         for (int i = 0; i < CH; i++) meas_hi[i] += int'(pwm_out[i]);
         meas_len++;
         tick();
      end
      chk("measure_end_seen", 32'(period_start), 1);
   endtask

   task automatic run_to_cnt(input int v);
      int w = 0;
      while (cnt_out != CNT_W'(v) && w < 1100) begin
         acc0 += int'(pwm_out[0]);
         tick();
         w++;
      end
      chk("reach_cnt", 32'(cnt_out), 32'(v));
   endtask

   task automatic write_duty(input int ch, input int val);
      duty_wr   = 1'b1;
      duty_ch   = 3'(ch);
      duty_data = 8'(val);
      tick();
      duty_wr   = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{0, 255, 64, 64, 256};
      tbl[1]  = '{0, 255, 0, 0, 256};
      tbl[2]  = '{0, 255, 255, 255, 256};
      tbl[3]  = '{0, 254, 255, 255, 255};
      tbl[4]  = '{0, 255, 200, 200, 256};
      tbl[5]  = '{1, 10, 4, 7, 20};
      tbl[6]  = '{0, 0, 1, 1, 1};
      tbl[7]  = '{0, 0, 0, 0, 1};
      tbl[8]  = '{1, 1, 1, 1, 2};
      tbl[9]  = '{0, 3, 2, 2, 4};
      tbl[10] = '{1, 10, 11, 20, 20};

      // Reset and initial programming while disabled.
      tick();
      tick();
      rst = 1'b0;
      write_duty(0, 64);
      write_duty(1, 0);
      write_duty(2, 255);
      write_duty(3, 200);
      en = 1'b1;
      measure();
      chk("init_ch0_high", meas_hi[0], 64);
      chk("init_ch1_high", meas_hi[1], 0);
      chk("init_ch2_high", meas_hi[2], 255);
      chk("init_ch3_high", meas_hi[3], 200);
      chk("init_len", meas_len, 256);

      // Mid-period shadow write only affects the next period.
      acc0 = 0;
      run_to_cnt(100);
      acc0 += int'(pwm_out[0]);
      write_duty(0, 32);
      for (int w = 0; w < 1100 && !period_start; w++) begin
         acc0 += int'(pwm_out[0]);
         tick();
      end
      chk("shadow_cur_period", acc0, 64);
      measure();
      chk("shadow_next_period", meas_hi[0], 32);

      // Write landing in the boundary cycle waits one more period.
      run_to_cnt(0);
      write_duty(0, 100);
      measure();
      chk("bnd_write_same_period", meas_hi[0], 32);
      measure();
      chk("bnd_write_next_period", meas_hi[0], 100);

      // Disable mid-period, write while disabled, including out-of-range indices.
      run_to_cnt(50);
      en = 1'b0;
      tick();
      chk("dis_pwm_low", 32'(pwm_out), 0);
      chk("dis_cnt_zero", 32'(cnt_out), 0);
      write_duty(1, 5);
      write_duty(5, 77);
      write_duty(7, 77);
      en = 1'b1;
      tick();
      chk("en_first_ch1", 32'(pwm_out[1]), 1);
      chk("en_first_ps", 32'(period_start), 1);
      measure();
      chk("en_ch1_high", meas_hi[1], 5);
      chk("en_ch0_kept", meas_hi[0], 100);
      chk("en_ch2_kept", meas_hi[2], 255);
      chk("en_ch3_kept", meas_hi[3], 200);
      chk("en_ch4_kept", meas_hi[4], 0);

      // Reset in the middle of a period.
      run_to_cnt(30);
      rst = 1'b1;
      tick();
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_cnt", 32'(cnt_out), 0);
      chk("rst_ps", 32'(period_start), 0);
      tick();
      rst = 1'b0;
      measure();
      chk("post_rst_len", meas_len, 256);
      chk("post_rst_ch0", meas_hi[0], 0);
      measure();
      chk("post_rst_len2", meas_len, 256);

      // Directed period/mode/duty table on channel 0.
      for (int v = 0; v < 11; v++) begin
         mode   = tbl[v].mode;
         period = 8'(tbl[v].per);
         write_duty(0, tbl[v].duty);
         measure();
         measure();
         chk($sformatf("tbl%0d_high", v), meas_hi[0], tbl[v].exp_hi);
         chk($sformatf("tbl%0d_len", v), meas_len, tbl[v].exp_len);
      end

      // Randomised run with small periods, checked every cycle by the model.
      period = 8'd7;
      for (int k = 0; k < 4000; k++) begin
         rst       = ($urandom_range(0, 299) == 0);
         en        = ($urandom_range(0, 19) != 0);
         duty_wr   = ($urandom_range(0, 2) == 0);
         duty_ch   = 3'($urandom_range(0, 7));
         duty_data = 8'($urandom_range(0, 20));
         if ($urandom_range(0, 39) == 0) period = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) mode = 1'($urandom_range(0, 1));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
